// File: rtl/add_round_key_ks.sv
// add_round_key_ks: registered AddRoundKey stage with an integrated sequential AES-128 key schedule
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   key_load      pulse: capture key_in as rk[0] and (re)start expansion
//   key_in        cipher key, bits [0:7] are byte 0
//   key_ready     all 11 round keys valid
//   state_valid   state_in/round valid this cycle
//   state_in      state from MixColumns, bits [0:7] are byte 0
//   round         round index 0..10 (ENC_DEC=1 selects rk[10-round])
//   out_valid     state_out valid
//   state_out     state_in ^ selected round key
//   err           sticky: beat seen without keys ready or with round > 10
//
// Build option ARK_OUT_REG_EN: defined -> registered output (latency 1);
// undefined -> combinational output (latency 0, state_out zero when not valid).

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign y = SBOX[{a, 3'b000} +: 8];
endmodule

module add_round_key_ks #(
  parameter bit ENC_DEC = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_load,
  input  logic [0:127] key_in,
  output logic         key_ready,
  input  logic         state_valid,
  input  logic [0:127] state_in,
  input  logic [3:0]   round,
  output logic         out_valid,
  output logic [0:127] state_out,
  output logic         err
);
  // Rcon indexed by cnt; entry 0 and the tail are unused padding
  localparam logic [0:127] RCON = 128'h0001020408102040801b3600000000_00;
  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;
  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           key_ready_q, key_ready_d;
  logic           err_q, err_d;
  logic [127:0]   rk_q [0:10];
  logic [127:0]   rk_d [0:10];
  logic [127:0]   prev_rk, next_rk;
  logic [31:0]    rot_w, sub_w, w0n, w1n, w2n, w3n;
  logic [7:0]     rcon;
  logic [3:0]     sel;
  logic           accept;
  logic [0:127]   xor_out;

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (.a(rot_w[8*i +: 8]), .y(sub_w[8*i +: 8]));
  end

  always_comb begin
    prev_rk = rk_q[cnt_q - 4'd1];
    rot_w   = {prev_rk[23:0], prev_rk[31:24]};
    rcon    = RCON[{cnt_q, 3'b000} +: 8];
    w0n     = prev_rk[127:96] ^ sub_w ^ {rcon, 24'h0};
    w1n     = prev_rk[95:64] ^ w0n;
    w2n     = prev_rk[63:32] ^ w1n;
    w3n     = prev_rk[31:0] ^ w2n;
    next_rk = {w0n, w1n, w2n, w3n};
    sel     = ENC_DEC ? 4'd10 - round : round;
    // a key load in the same cycle wins over the beat
    accept  = state_valid && key_ready_q && round <= 4'd10 && !key_load;
    xor_out = state_in ^ rk_q[sel];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    key_ready_d = key_ready_q;
    err_d       = err_q | (state_valid && !accept);
    rk_d        = rk_q;
    if (key_load) begin
      state_d     = EXPAND;
      cnt_d       = 4'd1;
      key_ready_d = 1'b0;
      // clear, but a beat dropped in the same cycle still sets err
      err_d       = state_valid;
      rk_d[0]     = key_in;
    end else if (state_q == EXPAND) begin
      rk_d[cnt_q] = next_rk;
      cnt_d       = cnt_q == 4'd10 ? cnt_q : cnt_q + 4'd1;
      state_d     = cnt_q == 4'd10 ? READY : EXPAND;
      key_ready_d = cnt_q == 4'd10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      key_ready_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_ready_q <= key_ready_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) rk_q <= rk_d;

  assign key_ready = key_ready_q;
  assign err       = err_q;

`ifdef ARK_OUT_REG_EN
  logic         out_valid_q, out_valid_d;
  logic [0:127] state_out_q, state_out_d;

  always_comb begin
    out_valid_d = accept;
    state_out_d = accept ? xor_out : state_out_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      state_out_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      state_out_q <= state_out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign state_out = state_out_q;
`else
  assign out_valid = accept;
  assign state_out = accept ? xor_out : '0;
`endif
endmodule
